// File: rtl/dmem_line_adapter_if.sv
// ============================================================================
// Module      : dmem_line_adapter_if
// Description : Word-side request bus and line-side memory port for the
//               MEM-stage line adapter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dmem_line_adapter_if;
  logic         dmem_action_cyc;
  logic         dmem_action_stb;
  logic         dmem_write;
  logic [1:0]   dmem_byte_enable;
  logic [15:0]  dmem_address;
  logic [15:0]  dmem_wdata;
  logic         dmem_resp;
  logic [15:0]  dmem_data_out;

  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [15:0]  pmem_byte_enable;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;

  // Environment view: issues word requests and answers line transactions.
  modport master (
    output dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
    output dmem_address, dmem_wdata,
    input  dmem_resp, dmem_data_out,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    output pmem_resp, pmem_rdata
  );

  // Adapter view.
  modport slave (
    input  dmem_action_cyc, dmem_action_stb, dmem_write, dmem_byte_enable,
    input  dmem_address, dmem_wdata,
    output dmem_resp, dmem_data_out,
    output pmem_address, pmem_read, pmem_write, pmem_wdata, pmem_byte_enable,
    input  pmem_resp, pmem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/dmem_line_adapter.sv
// ============================================================================
// Module      : dmem_line_adapter
// Description : 16-bit word requests onto a 128-bit line port, with a
//               single-line read buffer and write-through/no-allocate stores.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_line_adapter (
  input  logic                 clk,
  input  logic                 reset,
  dmem_line_adapter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [15:1]   r_addr;
  logic [15:0]   r_wdata;
  logic [1:0]    r_be;
  logic          r_abort;
  logic          r_buf_valid;
  logic [11:0]   r_buf_tag;
  logic [127:0]  r_buf_data;
  logic [15:0]   r_data_out;

  logic          w_req;
  logic [11:0]   w_req_tag;
  logic [2:0]    w_req_word;
  logic          w_req_hit;
  logic [11:0]   w_cur_tag;
  logic [2:0]    w_cur_word;
  logic          w_cur_hit;
  logic          w_abort;
  logic [15:0]   w_line_be;
  logic [127:0]  w_line_wdata;
  logic [127:0]  w_merged;
  logic [15:0]   w_buf_word;
  logic [15:0]   w_fill_word;

  assign w_req      = bus.dmem_action_cyc & bus.dmem_action_stb;
  assign w_req_tag  = bus.dmem_address[15:4];
  assign w_req_word = bus.dmem_address[3:1];
  assign w_req_hit  = r_buf_valid && (r_buf_tag == w_req_tag);

  assign w_cur_tag  = r_addr[15:4];
  assign w_cur_word = r_addr[3:1];
  assign w_cur_hit  = r_buf_valid && (r_buf_tag == w_cur_tag);

  // A flush seen in the same cycle as pmem_resp must still suppress dmem_resp.
  assign w_abort    = r_abort | ~bus.dmem_action_cyc;

  assign w_line_be    = {14'd0, r_be} << {w_cur_word, 1'b0};
  assign w_line_wdata = {8{r_wdata}};
  assign w_buf_word   = r_buf_data[{w_req_word, 4'b0000} +: 16];
  assign w_fill_word  = bus.pmem_rdata[{w_cur_word, 4'b0000} +: 16];

  always_comb begin
    w_merged = r_buf_data;
    for (int i = 0; i < 16; i++) begin
      if (w_line_be[i]) begin
        w_merged[i*8 +: 8] = w_line_wdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          if (bus.dmem_write) begin
            w_next = S_WRITE;
          end else if (w_req_hit) begin
            w_next = S_RESP;
          end else begin
            w_next = S_FETCH;
          end
        end
      end
      S_FETCH, S_WRITE: begin
        if (bus.pmem_resp) begin
          w_next = w_abort ? S_IDLE : S_RESP;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_abort <= 1'b0;
    end else if (w_next == S_IDLE) begin
      r_abort <= 1'b0;
    end else if ((r_state == S_FETCH || r_state == S_WRITE) && !bus.dmem_action_cyc) begin
      r_abort <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_buf_valid <= 1'b0;
      r_buf_tag   <= '0;
      r_buf_data  <= '0;
      r_data_out  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (bus.dmem_write) begin
              r_addr  <= bus.dmem_address[15:1];
              r_wdata <= bus.dmem_wdata;
              r_be    <= bus.dmem_byte_enable;
            end else if (w_req_hit) begin
              r_data_out <= w_buf_word;
            end else begin
              r_addr <= bus.dmem_address[15:1];
            end
          end
        end
        S_FETCH: begin
          // Fill is captured even when aborted; the data is still valid.
          if (bus.pmem_resp) begin
            r_buf_data  <= bus.pmem_rdata;
            r_buf_tag   <= w_cur_tag;
            r_buf_valid <= 1'b1;
            r_data_out  <= w_fill_word;
          end
        end
        S_WRITE: begin
          if (bus.pmem_resp && w_cur_hit) begin
            r_buf_data <= w_merged;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read        = (r_state == S_FETCH);
  assign bus.pmem_write       = (r_state == S_WRITE);
  assign bus.pmem_address     = {r_addr[15:4], 4'b0000};
  assign bus.pmem_wdata       = w_line_wdata;
  assign bus.pmem_byte_enable = (r_state == S_WRITE) ? w_line_be : 16'd0;
  assign bus.dmem_resp        = (r_state == S_RESP);
  assign bus.dmem_data_out    = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_dmem_line_adapter.sv
// ============================================================================
// Module      : tb_dmem_line_adapter
// Description : Directed and randomized checks of dmem_line_adapter against a
//               line-memory model plus a one-line buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_line_adapter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_line_adapter_if bus();

  dmem_line_adapter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Next-level memory contents and the expected buffer occupancy.
  logic [127:0] mem [int];
  bit           ref_valid;
  logic [11:0]  ref_tag;

  function automatic logic [127:0] line_of(input logic [11:0] tag);
    logic [127:0] l;
    if (mem.exists(int'(tag))) return mem[int'(tag)];
    for (int i = 0; i < 8; i++) l[i*16 +: 16] = 16'(int'(tag) * 29 + i * 1111 + 'hA5C3);
    return l;
  endfunction

  function automatic logic [15:0] word_of(input logic [11:0] tag, input logic [2:0] w);
    logic [127:0] l;
    l = line_of(tag);
    return l[{w, 4'b0000} +: 16];
  endfunction

  task automatic apply_line_write(input logic [11:0] tag, input logic [127:0] wd, input logic [15:0] be);
    logic [127:0] l;
    l = line_of(tag);
    for (int b = 0; b < 16; b++) if (be[b]) l[b*8 +: 8] = wd[b*8 +: 8];
    mem[int'(tag)] = l;
  endtask

  task automatic drop_req();
    bus.dmem_action_cyc = 1'b0;
    bus.dmem_action_stb = 1'b0;
  endtask

  // One complete word access, answering line transactions after lat cycles.
  task automatic access(input bit wr, input logic [1:0] be, input logic [15:0] addr,
                        input logic [15:0] wd, input int lat,
                        output int k, output int nrd, output int nwr,
                        output logic [15:0] rdata, output logic [15:0] pa,
                        output logic [15:0] pbe, output logic [127:0] pwd,
                        output bit bad_both, output bit bad_stable, output bit timeout);
    int  wait_n;
    bit  seen;
    k = 0; nrd = 0; nwr = 0; rdata = 'x; pa = 'x; pbe = 'x; pwd = 'x;
    bad_both = 0; bad_stable = 0; timeout = 1; wait_n = 0; seen = 0;
    @(negedge clk);
    bus.dmem_action_cyc  = 1'b1;
    bus.dmem_action_stb  = 1'b1;
    bus.dmem_write       = wr;
    bus.dmem_byte_enable = be;
    bus.dmem_address     = addr;
    bus.dmem_wdata       = wd;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (bus.pmem_read && bus.pmem_write) bad_both = 1;
      if (bus.dmem_resp) begin
        k = c; rdata = bus.dmem_data_out; timeout = 0;
        break;
      end
      if (bus.pmem_read || bus.pmem_write) begin
        if (!seen) begin
          seen = 1; pa = bus.pmem_address; pbe = bus.pmem_byte_enable; pwd = bus.pmem_wdata;
          if (bus.pmem_read) nrd++; else nwr++;
        end else if (pa !== bus.pmem_address || pwd !== bus.pmem_wdata) begin
          bad_stable = 1;
        end
        wait_n++;
        if (wait_n == lat) begin
          if (bus.pmem_read) bus.pmem_rdata = line_of(pa[15:4]);
          else apply_line_write(pa[15:4], bus.pmem_wdata, bus.pmem_byte_enable);
          bus.pmem_resp = 1'b1;
          seen = 0; wait_n = 0;
        end
      end
    end
    @(negedge clk);
    drop_req();
  endtask

  int           k, nrd, nwr;
  logic [15:0]  rdata, pa, pbe;
  logic [127:0] pwd;
  bit           bad_both, bad_stable, timeout;

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_resp: got %b expected 0", bus.dmem_resp); end
    n_checks++; if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_read: got %b expected 0", bus.pmem_read); end
    n_checks++; if (bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_pmem_write: got %b expected 0", bus.pmem_write); end
    n_checks++; if (bus.dmem_data_out !== 16'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0000", bus.dmem_data_out); end
    n_checks++; if (bus.pmem_address !== 16'h0) begin n_fail++; $display("FAIL reset_pmem_address: got %h expected 0000", bus.pmem_address); end
    n_checks++; if (bus.pmem_byte_enable !== 16'h0) begin n_fail++; $display("FAIL reset_pmem_be: got %h expected 0000", bus.pmem_byte_enable); end
    reset = 1'b0;
    ref_valid = 0; ref_tag = '0;
  endtask

  task automatic test_read_miss();
    logic [127:0] l;
    l = line_of(12'h100);
    l[31:16]   = 16'hBEEF;
    l[127:112] = 16'h1234;
    mem[12'h100] = l;
    access(0, 2'b11, 16'h1002, 16'h0, 3, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL miss_timeout: got no dmem_resp expected one"); end
    n_checks++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL miss_pmem_ops: got rd=%0d wr=%0d expected rd=1 wr=0", nrd, nwr); end
    n_checks++; if (pa !== 16'h1000) begin n_fail++; $display("FAIL miss_address: got %h expected 1000", pa); end
    n_checks++; if (rdata !== word_of(12'h100, 3'd1)) begin n_fail++; $display("FAIL miss_data: got %h expected %h", rdata, word_of(12'h100, 3'd1)); end
    n_checks++; if (k !== 3 + 1) begin n_fail++; $display("FAIL miss_latency: got %0d edges expected %0d", k, 4); end
    ref_valid = 1; ref_tag = 12'h100;
  endtask

  task automatic test_read_hit();
    access(0, 2'b11, 16'h100E, 16'h0, 3, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL hit_pmem_read: got %0d reads expected 0", nrd); end
    n_checks++; if (k !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d edges expected 1", k); end
    n_checks++; if (rdata !== word_of(12'h100, 3'd7)) begin n_fail++; $display("FAIL hit_data: got %h expected %h", rdata, word_of(12'h100, 3'd7)); end
    @(negedge clk);
    n_checks++; if (bus.dmem_resp !== 1'b0) begin n_fail++; $display("FAIL hit_resp_pulse: got %b expected 0", bus.dmem_resp); end
    n_checks++; if (bus.dmem_data_out !== word_of(12'h100, 3'd7)) begin n_fail++; $display("FAIL hit_data_hold: got %h expected %h", bus.dmem_data_out, word_of(12'h100, 3'd7)); end
  endtask

  task automatic test_store_hit();
    access(1, 2'b10, 16'h1003, 16'h00AA, 2, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nwr !== 1 || nrd !== 0) begin n_fail++; $display("FAIL st_hit_ops: got rd=%0d wr=%0d expected rd=0 wr=1", nrd, nwr); end
    n_checks++; if (pbe !== 16'h0008) begin n_fail++; $display("FAIL st_hit_be: got %h expected 0008", pbe); end
    n_checks++; if (pwd !== {8{16'h00AA}}) begin n_fail++; $display("FAIL st_hit_wdata: got %h expected %h", pwd, {8{16'h00AA}}); end
    n_checks++; if (pa !== 16'h1000) begin n_fail++; $display("FAIL st_hit_address: got %h expected 1000", pa); end
    n_checks++; if (k !== 2 + 1) begin n_fail++; $display("FAIL st_hit_latency: got %0d edges expected 3", k); end
    access(0, 2'b11, 16'h1002, 16'h0, 3, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL st_hit_reread_ops: got %0d reads expected 0", nrd); end
    n_checks++; if (rdata !== word_of(12'h100, 3'd1)) begin n_fail++; $display("FAIL st_hit_merge: got %h expected %h", rdata, word_of(12'h100, 3'd1)); end
  endtask

  task automatic test_store_miss();
    access(1, 2'b11, 16'h2000, 16'h5555, 2, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (pbe !== 16'h0003) begin n_fail++; $display("FAIL st_miss_be: got %h expected 0003", pbe); end
    n_checks++; if (pa !== 16'h2000) begin n_fail++; $display("FAIL st_miss_address: got %h expected 2000", pa); end
    access(0, 2'b11, 16'h1002, 16'h0, 3, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 0) begin n_fail++; $display("FAIL st_miss_noalloc: got %0d reads expected 0", nrd); end
    access(0, 2'b11, 16'h2000, 16'h0, 2, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 1) begin n_fail++; $display("FAIL st_miss_refetch: got %0d reads expected 1", nrd); end
    n_checks++; if (rdata !== 16'h5555) begin n_fail++; $display("FAIL st_miss_data: got %h expected 5555", rdata); end
    ref_valid = 1; ref_tag = 12'h200;
  endtask

  task automatic test_abort();
    int  wait_n, fills;
    bit  saw_resp, seen;
    saw_resp = 0; seen = 0; wait_n = 0; fills = 0;
    @(negedge clk);
    bus.dmem_action_cyc = 1'b1; bus.dmem_action_stb = 1'b1;
    bus.dmem_write = 1'b0; bus.dmem_address = 16'h3000;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.pmem_read) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL abort_start: got no pmem_read expected one"); end
    wait_n = 1;
    @(negedge clk);
    drop_req();
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      bus.pmem_resp = 1'b0;
      if (bus.dmem_resp) saw_resp = 1;
      if (bus.pmem_read) begin
        wait_n++;
        if (wait_n == 5) begin
          bus.pmem_rdata = line_of(12'h300); bus.pmem_resp = 1'b1; fills++; wait_n = 0;
        end
      end
    end
    n_checks++; if (saw_resp) begin n_fail++; $display("FAIL abort_resp: got dmem_resp expected none"); end
    n_checks++; if (fills !== 1 || bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL abort_fill: got fills=%0d read=%b expected fills=1 read=0", fills, bus.pmem_read); end
    ref_valid = 1; ref_tag = 12'h300;
    access(0, 2'b11, 16'h3004, 16'h0, 3, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 0 || k !== 1) begin n_fail++; $display("FAIL abort_hit: got rd=%0d edges=%0d expected rd=0 edges=1", nrd, k); end
    n_checks++; if (rdata !== word_of(12'h300, 3'd2)) begin n_fail++; $display("FAIL abort_hit_data: got %h expected %h", rdata, word_of(12'h300, 3'd2)); end
  endtask

  task automatic test_reset_mid_write();
    bit seen;
    seen = 0;
    @(negedge clk);
    bus.dmem_action_cyc = 1'b1; bus.dmem_action_stb = 1'b1; bus.dmem_write = 1'b1;
    bus.dmem_byte_enable = 2'b11; bus.dmem_address = 16'h1002; bus.dmem_wdata = 16'h1357;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (bus.pmem_write) seen = 1;
    end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (!seen || bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL rst_write_drop: got seen=%b write=%b expected seen=1 write=0", seen, bus.pmem_write); end
    n_checks++; if (bus.pmem_byte_enable !== 16'h0) begin n_fail++; $display("FAIL rst_write_be: got %h expected 0000", bus.pmem_byte_enable); end
    drop_req();
    @(negedge clk);
    reset = 1'b0;
    ref_valid = 0;
    access(0, 2'b11, 16'h1002, 16'h0, 2, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (nrd !== 1) begin n_fail++; $display("FAIL rst_refetch: got %0d reads expected 1", nrd); end
    n_checks++; if (rdata !== word_of(12'h100, 3'd1)) begin n_fail++; $display("FAIL rst_refetch_data: got %h expected %h", rdata, word_of(12'h100, 3'd1)); end
    ref_valid = 1; ref_tag = 12'h100;
  endtask

  task automatic test_back_to_back();
    access(1, 2'b11, 16'h1004, 16'hC0DE, 1, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    access(0, 2'b11, 16'h1004, 16'h0, 1, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
    n_checks++; if (rdata !== 16'hC0DE || nrd !== 0) begin n_fail++; $display("FAIL b2b_store_load: got %h rd=%0d expected c0de rd=0", rdata, nrd); end
  endtask

  task automatic test_random();
    logic [11:0] pool [4];
    logic [11:0] tag;
    logic [2:0]  w;
    logic [15:0] addr, wd, exp_data;
    logic [1:0]  be;
    bit          wr, hit;
    int          lat;
    pool[0] = 12'h100; pool[1] = 12'h101; pool[2] = 12'h200; pool[3] = 12'hFFF;
    for (int it = 0; it < 40; it++) begin
      tag  = pool[$urandom_range(0, 3)];
      w    = 3'($urandom_range(0, 7));
      addr = {tag, w, 1'($urandom_range(0, 1))};
      wr   = ($urandom_range(0, 2) == 0);
      be   = 2'($urandom_range(1, 3));
      wd   = 16'($urandom);
      lat  = $urandom_range(1, 4);
      hit  = !wr && ref_valid && (ref_tag == tag);
      access(wr, be, addr, wd, lat, k, nrd, nwr, rdata, pa, pbe, pwd, bad_both, bad_stable, timeout);
      exp_data = word_of(tag, w);
      n_checks++; if (timeout || bad_both || bad_stable) begin n_fail++; $display("FAIL rnd_protocol[%0d]: got to=%b both=%b unstable=%b expected 0 0 0", it, timeout, bad_both, bad_stable); end
      n_checks++; if (nrd !== ((wr || hit) ? 0 : 1) || nwr !== (wr ? 1 : 0)) begin n_fail++; $display("FAIL rnd_ops[%0d]: got rd=%0d wr=%0d for wr=%b hit=%b", it, nrd, nwr, wr, hit); end
      n_checks++; if (k !== (hit ? 1 : lat + 1)) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d edges expected %0d", it, k, hit ? 1 : lat + 1); end
      if (wr) begin
        n_checks++; if (pbe !== ({14'd0, be} << (2 * w)) || pwd !== {8{wd}} || pa !== {tag, 4'h0}) begin n_fail++; $display("FAIL rnd_store[%0d]: got a=%h be=%h expected a=%h be=%h", it, pa, pbe, {tag, 4'h0}, {14'd0, be} << (2 * w)); end
      end else begin
        n_checks++; if (rdata !== exp_data) begin n_fail++; $display("FAIL rnd_load[%0d]: got %h expected %h", it, rdata, exp_data); end
        ref_valid = 1; ref_tag = tag;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.dmem_action_cyc = 1'b0; bus.dmem_action_stb = 1'b0; bus.dmem_write = 1'b0;
    bus.dmem_byte_enable = 2'b00; bus.dmem_address = 16'h0; bus.dmem_wdata = 16'h0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    test_reset();
    test_read_miss();
    test_read_hit();
    test_store_hit();
    test_store_miss();
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
